// File: rtl/spram_pwr_seq.sv
// spram_pwr_seq: power-mode sequencer for the SPRAM instruction/data memories.
// Moves the memories ACTIVE -> STANDBY -> SLEEP while the core sits in WFI.
// On a wake request it returns them through a timed WAKE phase.
// mem_ready gates core access whenever the RAMs are not fully awake.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   wfi           core idle in WFI (level)
//   wake_evt      wake request from interrupt/timer (level)
//   mem_standby   SPRAM STANDBY control
//   mem_sleep     SPRAM SLEEP control
//   mem_ready     memories accessible to the core
//   pwr_state     00 ACTIVE, 01 STANDBY, 10 SLEEP, 11 WAKE
//   sleep_entries saturating count of SLEEP entries
module spram_pwr_seq #(
  parameter int unsigned SLEEP_DELAY = 1024,
  parameter int unsigned WAKE_CYCLES = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wfi,
  input  logic        wake_evt,
  output logic        mem_standby,
  output logic        mem_sleep,
  output logic        mem_ready,
  output logic [1:0]  pwr_state,
  output logic [15:0] sleep_entries
);

  localparam int unsigned ENT_W = 16;
  localparam logic [CNT_W-1:0] SLEEP_LAST = CNT_W'(SLEEP_DELAY - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'b00,
    ST_STANDBY = 2'b01,
    ST_SLEEP   = 2'b10,
    ST_WAKE    = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ent_inc;
  logic             wake;
  logic             standby_nxt;
  logic             sleep_nxt;
  logic             ready_nxt;

  // Next-state, counter and next-output decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ent_inc     = 1'b0;
    wake        = wake_evt | ~wfi;
    standby_nxt = 1'b0;
    sleep_nxt   = 1'b0;
    ready_nxt   = 1'b0;

    unique case (state)
      ST_ACTIVE: begin
        cnt_nxt = '0;
        if (wfi && !wake) state_nxt = ST_STANDBY;
      end
      ST_STANDBY: begin
        // Wake wins over escalation on the same cycle
        if (wake) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = '0;
        end else if (cnt == SLEEP_LAST) begin
          state_nxt = ST_SLEEP;
          cnt_nxt   = '0;
          ent_inc   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SLEEP: begin
        cnt_nxt = '0;
        if (wake) state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        // Inputs ignored: the wake window always runs to completion
        if (cnt == WAKE_LAST) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_ACTIVE;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are a Moore decode of the state being entered, then registered
    unique case (state_nxt)
      ST_ACTIVE:  ready_nxt   = 1'b1;
      ST_STANDBY: standby_nxt = 1'b1;
      ST_SLEEP: begin
        standby_nxt = 1'b1;
        sleep_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ACTIVE;
      cnt           <= '0;
      mem_standby   <= 1'b0;
      mem_sleep     <= 1'b0;
      mem_ready     <= 1'b1;
      pwr_state     <= 2'b00;
      sleep_entries <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mem_standby <= standby_nxt;
      mem_sleep   <= sleep_nxt;
      mem_ready   <= ready_nxt;
      pwr_state   <= state_nxt;
      if (ent_inc && (sleep_entries != '1))
        sleep_entries <= sleep_entries + ENT_W'(1);
    end
  end

endmodule

// File: tb/tb_spram_pwr_seq.sv
// tb_spram_pwr_seq: randomized and directed scoreboard bench for spram_pwr_seq.
// The driver applies inputs on the falling edge and pushes the outputs a
// countdown-based reference model predicts for the following cycle.
// The monitor pops one prediction after every rising edge and compares.
module tb_spram_pwr_seq;

  localparam int unsigned SLEEP_DELAY = 8;
  localparam int unsigned WAKE_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wfi;
  logic        wake_evt;
  logic        mem_standby;
  logic        mem_sleep;
  logic        mem_ready;
  logic [1:0]  pwr_state;
  logic [15:0] sleep_entries;

  spram_pwr_seq #(
    .SLEEP_DELAY(SLEEP_DELAY),
    .WAKE_CYCLES(WAKE_CYCLES),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wfi(wfi),
    .wake_evt(wake_evt),
    .mem_standby(mem_standby),
    .mem_sleep(mem_sleep),
    .mem_ready(mem_ready),
    .pwr_state(pwr_state),
    .sleep_entries(sleep_entries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        standby;
    logic        sleep;
    logic        ready;
    logic [1:0]  state;
    logic [15:0] entries;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 active, 1 standby, 2 sleep, 3 wake;
  // rem counts the cycles still to spend in the current timed mode.
  int m_mode = 0;
  int m_rem  = 0;
  int m_ent  = 0;

  function automatic void model_step(input logic r, input logic w, input logic e);
    logic wk;
    wk = e | ~w;
    if (r) begin
      m_mode = 0;
      m_rem  = 0;
      m_ent  = 0;
    end else begin
      case (m_mode)
        0: if (w && !e) begin m_mode = 1; m_rem = SLEEP_DELAY; end
        1: begin
          if (wk) m_mode = 0;
          else if (m_rem == 1) begin
            m_mode = 2;
            if (m_ent < 65535) m_ent = m_ent + 1;
          end else m_rem = m_rem - 1;
        end
        2: if (wk) begin m_mode = 3; m_rem = WAKE_CYCLES; end
        default: begin
          if (m_rem == 1) m_mode = 0;
          else m_rem = m_rem - 1;
        end
      endcase
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.standby = (m_mode == 1) || (m_mode == 2);
    x.sleep   = (m_mode == 2);
    x.ready   = (m_mode == 0);
    x.state   = 2'(m_mode);
    x.entries = 16'(m_ent);
    return x;
  endfunction

  task automatic step(input logic r, input logic w, input logic e);
    @(negedge clk);
    rst      = r;
    wfi      = w;
    wake_evt = e;
    model_step(r, w, e);
    exp_q.push_back(model_out());
  endtask

  // Monitor: one output per cycle, compared against the oldest prediction
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (mem_standby !== x.standby || mem_sleep !== x.sleep ||
            mem_ready !== x.ready || pwr_state !== x.state ||
            sleep_entries !== x.entries) begin
          errors++;
          $display("FAIL outputs t=%0t got sb=%b sl=%b rdy=%b st=%b ent=%0d want sb=%b sl=%b rdy=%b st=%b ent=%0d",
                   $time, mem_standby, mem_sleep, mem_ready, pwr_state, sleep_entries,
                   x.standby, x.sleep, x.ready, x.state, x.entries);
        end
        if (mem_sleep === 1'b1 && mem_standby !== 1'b1) begin
          errors++;
          $display("FAIL sleep_without_standby t=%0t got standby=%b want 1", $time, mem_standby);
        end
      end
    end
  end

  initial begin
    int p;
    rst = 1'b1; wfi = 1'b0; wake_evt = 1'b0;

    // Reset then idle
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (100) step(0, 0, 0);

    // Full sleep cycle: enter, escalate, wake pulse, wait for ready
    repeat (20) step(0, 1, 0);
    step(0, 1, 1);
    repeat (6) step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // Early wake: wfi drops after 4 standby cycles
    repeat (5) step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // Simultaneous wfi and wake_evt in ACTIVE stays ACTIVE
    repeat (4) step(0, 1, 1);
    step(0, 0, 0);

    // Wake on the last standby cycle wins over escalation
    repeat (8) step(0, 1, 0);
    step(0, 1, 1);
    repeat (2) step(0, 0, 0);

    // Reset on the second WAKE cycle
    repeat (12) step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    step(1, 1, 0);
    repeat (3) step(0, 0, 0);

    // Randomized segments with varying idle bias
    for (int seg = 0; seg < 50; seg++) begin
      p = ($urandom_range(0, 1) == 1) ? 97 : 75;
      for (int c = 0; c < 40; c++)
        step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0,
             ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end
    repeat (WAKE_CYCLES + 2) step(0, 0, 0);

    // Saturation: preload the entry count just below full
    @(negedge clk);
    rst = 1'b0; wfi = 1'b0; wake_evt = 1'b0;
    force dut.sleep_entries = 16'hFFFE;
    m_ent = 65534;
    model_step(1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_out());
    @(negedge clk);
    release dut.sleep_entries;
    model_step(1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_out());
    for (int k = 0; k < 2; k++) begin
      repeat (10) step(0, 1, 0);
      step(0, 0, 1);
      repeat (5) step(0, 0, 0);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
